// File: rtl/miriscv_prefetch_fetch_stage.sv
// Prefetch fetch stage: circular {pc, instr} buffer fed by in-order memory, flushed by kill/force.
// Define MIRISCV_PREFETCH_BYPASS_EN to forward a response to decode in the cycle it arrives into an empty buffer.
module miriscv_prefetch_fetch_stage #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned XLEN            = 32,
    parameter int unsigned ILEN            = 32
) (
    input  logic            clk_i,
    input  logic            arstn_i,

    input  logic            cu_kill_f_i,
    input  logic            cu_stall_f_i,
    input  logic            cu_force_f_i,
    input  logic [XLEN-1:0] cu_force_pc_i,
    output logic            f_stall_req_o,

    input  logic            instr_rvalid_i,
    input  logic [XLEN-1:0] instr_rdata_i,
    output logic            instr_req_o,
    output logic [XLEN-1:0] instr_addr_o,

    output logic [ILEN-1:0] f_instr_o,
    output logic [XLEN-1:0] f_current_pc_o,
    output logic [XLEN-1:0] f_next_pc_o,
    output logic            f_valid_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    // Headroom so back-to-back flushes can stack discarded requests on top of live ones.
    localparam int unsigned OUT_W = CNT_W + 4;
    localparam logic [OUT_W-1:0] DEPTH_LIM = OUT_W'(FIFO_DEPTH);
    localparam logic [OUT_W-1:0] MAX_LIM   = OUT_W'(MAX_OUTSTANDING);

    logic [XLEN-1:0]  pc_mem    [FIFO_DEPTH];
    logic [ILEN-1:0]  instr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [OUT_W-1:0] outstanding_q;
    logic [OUT_W-1:0] discard_q;
    logic [XLEN-1:0]  fetch_pc_q;
    logic [XLEN-1:0]  resp_pc_q;
    logic             issue_en_q;

    logic             flush;
    logic             fifo_empty;
    logic             resp_accept;
    logic             bypass;
    logic             push;
    logic             pop;
    logic [OUT_W-1:0] live_out;
    logic [OUT_W-1:0] occ_ext;

    assign flush       = cu_kill_f_i | cu_force_f_i;
    assign fifo_empty  = (count_q == '0);
    assign live_out    = outstanding_q - discard_q;
    assign occ_ext     = OUT_W'(count_q);
    assign resp_accept = instr_rvalid_i & (discard_q == '0) & ~flush;

    assign instr_req_o  = issue_en_q & ~flush & (live_out < MAX_LIM)
                        & ((occ_ext + live_out) < DEPTH_LIM);
    assign instr_addr_o = fetch_pc_q;

`ifdef MIRISCV_PREFETCH_BYPASS_EN
    assign bypass = fifo_empty & resp_accept;
`else
    assign bypass = 1'b0;
`endif

    assign f_valid_o      = (~fifo_empty | bypass) & ~flush;
    assign f_current_pc_o = bypass ? resp_pc_q : pc_mem[rd_ptr_q];
    assign f_instr_o      = bypass ? instr_rdata_i[ILEN-1:0] : instr_mem[rd_ptr_q];
    assign f_next_pc_o    = f_current_pc_o + XLEN'(4);
    assign f_stall_req_o  = ~f_valid_o & ~flush;

    // A bypassed response consumed by decode never touches the buffer.
    assign pop  = f_valid_o & ~cu_stall_f_i & ~bypass;
    assign push = resp_accept & ~(bypass & ~cu_stall_f_i);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            fetch_pc_q    <= '0;
            resp_pc_q     <= '0;
            issue_en_q    <= 1'b0;
        end else begin
            outstanding_q <= outstanding_q + OUT_W'(instr_req_o) - OUT_W'(instr_rvalid_i);
            if (flush) begin
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
                count_q   <= '0;
                discard_q <= outstanding_q - OUT_W'(instr_rvalid_i);
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
                if (instr_rvalid_i && (discard_q != '0)) begin
                    discard_q <= discard_q - OUT_W'(1);
                end
            end
            // Issue stays off after reset until the control unit supplies a boot address.
            if (cu_force_f_i) begin
                fetch_pc_q <= cu_force_pc_i;
                resp_pc_q  <= cu_force_pc_i;
                issue_en_q <= 1'b1;
            end else begin
                if (instr_req_o) begin
                    fetch_pc_q <= fetch_pc_q + XLEN'(4);
                end
                if (resp_accept) begin
                    resp_pc_q <= resp_pc_q + XLEN'(4);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr_q]    <= resp_pc_q;
            instr_mem[wr_ptr_q] <= instr_rdata_i[ILEN-1:0];
        end
    end

endmodule

// File: tb/tb_miriscv_prefetch_fetch_stage.sv
// Bench for miriscv_prefetch_fetch_stage: queue-based reference model plus bench-owned in-order memory.
// Directed scenarios cover boot, stall saturation, force/kill flushes, PC wrap and mid-flight reset.
module tb_miriscv_prefetch_fetch_stage;

    localparam int FIFO_DEPTH      = 4;
    localparam int MAX_OUTSTANDING = 2;

    logic        clk_i = 1'b0;
    logic        arstn_i = 1'b0;
    logic        cu_kill_f_i = 1'b0;
    logic        cu_stall_f_i = 1'b0;
    logic        cu_force_f_i = 1'b0;
    logic [31:0] cu_force_pc_i = '0;
    logic        f_stall_req_o;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic [31:0] f_instr_o;
    logic [31:0] f_current_pc_o;
    logic [31:0] f_next_pc_o;
    logic        f_valid_o;

    miriscv_prefetch_fetch_stage #(
        .FIFO_DEPTH      (FIFO_DEPTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk_i          (clk_i),
        .arstn_i        (arstn_i),
        .cu_kill_f_i    (cu_kill_f_i),
        .cu_stall_f_i   (cu_stall_f_i),
        .cu_force_f_i   (cu_force_f_i),
        .cu_force_pc_i  (cu_force_pc_i),
        .f_stall_req_o  (f_stall_req_o),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .f_instr_o      (f_instr_o),
        .f_current_pc_o (f_current_pc_o),
        .f_next_pc_o    (f_next_pc_o),
        .f_valid_o      (f_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
    typedef struct { logic stale; logic [31:0] addr; } flight_t;
    typedef struct { logic [31:0] addr; int due; } memreq_t;

    entry_t      mq[$];
    flight_t     inflight[$];
    memreq_t     memq[$];
    logic [31:0] m_fetch_pc = '0;
    logic [31:0] m_resp_pc = '0;
    logic        m_issue_en = 1'b0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic kill, input logic stall, input logic force_en,
                                 input logic [31:0] pc, input int cycles);
        cu_kill_f_i   = kill;
        cu_stall_f_i  = stall;
        cu_force_f_i  = force_en;
        cu_force_pc_i = pc;
        repeat (cycles) nextCycle();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req"},   32'(instr_req_o),   32'd0);
        checkOutput({tag, "_addr"},  instr_addr_o,       32'd0);
        checkOutput({tag, "_valid"}, 32'(f_valid_o),     32'd0);
        checkOutput({tag, "_stall"}, 32'(f_stall_req_o), 32'd1);
        checkOutput({tag, "_instr"}, f_instr_o,          32'd0);
        checkOutput({tag, "_pc"},    f_current_pc_o,     32'd0);
        checkOutput({tag, "_npc"},   f_next_pc_o,        32'd4);
    endtask

    // Reference model and memory: judge outputs at each falling edge, then advance to the next cycle.
    initial begin : model_proc
        entry_t      e;
        flight_t     fl;
        memreq_t     mr;
        logic        flush, accepted, bypass, exp_req, exp_valid, consumed;
        logic [31:0] exp_pc, exp_instr, resp_addr;
        int          live;
        forever begin
            @(negedge clk_i);
            if (!arstn_i) begin
                checkResetOutputs("model_rst");
                mq.delete();
                inflight.delete();
                memq.delete();
                m_fetch_pc = '0;
                m_resp_pc  = '0;
                m_issue_en = 1'b0;
            end else begin
                flush = cu_kill_f_i | cu_force_f_i;
                live = 0;
                foreach (inflight[i]) if (!inflight[i].stale) live++;
                exp_req = m_issue_en && !flush && (live < MAX_OUTSTANDING)
                          && ((mq.size() + live) < FIFO_DEPTH);
                accepted  = 1'b0;
                resp_addr = '0;
                if (instr_rvalid_i && inflight.size() > 0) begin
                    fl        = inflight.pop_front();
                    accepted  = !fl.stale && !flush;
                    resp_addr = fl.addr;
                end
`ifdef MIRISCV_PREFETCH_BYPASS_EN
                bypass = accepted && (mq.size() == 0);
`else
                bypass = 1'b0;
`endif
                exp_valid = !flush && ((mq.size() > 0) || bypass);
                exp_pc    = '0;
                exp_instr = '0;
                if (bypass) begin
                    exp_pc    = m_resp_pc;
                    exp_instr = mem_data(resp_addr);
                end else if (mq.size() > 0) begin
                    exp_pc    = mq[0].pc;
                    exp_instr = mq[0].instr;
                end

                checkOutput("model_req", 32'(instr_req_o), 32'(exp_req));
                if (exp_req) checkOutput("model_addr", instr_addr_o, m_fetch_pc);
                checkOutput("model_valid", 32'(f_valid_o), 32'(exp_valid));
                checkOutput("model_stall_req", 32'(f_stall_req_o), 32'(!exp_valid && !flush));
                if (exp_valid) begin
                    checkOutput("model_pc",    f_current_pc_o, exp_pc);
                    checkOutput("model_instr", f_instr_o,      exp_instr);
                    checkOutput("model_npc",   f_next_pc_o,    exp_pc + 32'd4);
                end

                consumed = exp_valid && !cu_stall_f_i;
                if (flush) begin
                    mq.delete();
                    foreach (inflight[i]) inflight[i].stale = 1'b1;
                end else begin
                    if (consumed && !bypass) void'(mq.pop_front());
                    if (accepted) begin
                        if (!(bypass && consumed)) begin
                            e.pc    = m_resp_pc;
                            e.instr = mem_data(resp_addr);
                            mq.push_back(e);
                        end
                        m_resp_pc = m_resp_pc + 32'd4;
                    end
                end
                if (instr_req_o) begin
                    fl.stale = flush;
                    fl.addr  = m_fetch_pc;
                    inflight.push_back(fl);
                    mr.addr = instr_addr_o;
                    mr.due  = cyc + mem_lat;
                    memq.push_back(mr);
                    if (!flush) m_fetch_pc = m_fetch_pc + 32'd4;
                end
                if (cu_force_f_i) begin
                    m_fetch_pc = cu_force_pc_i;
                    m_resp_pc  = cu_force_pc_i;
                    m_issue_en = 1'b1;
                end
            end
            cyc++;
            @(posedge clk_i);
            #2;
            if (arstn_i && memq.size() > 0 && memq[0].due <= cyc) begin
                mr             = memq.pop_front();
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = mem_data(mr.addr);
            end else begin
                instr_rvalid_i = 1'b0;
                instr_rdata_i  = '0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : directed
        logic        found;
        logic [31:0] saved_pc;

        // Boot: reset holds outputs idle, nothing is fetched until the first force.
        repeat (3) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        checkResetOutputs("boot_rst");
        nextCycle();
        arstn_i = 1'b1;
        @(negedge clk_i);
        checkOutput("no_issue_before_force", 32'(instr_req_o), 32'd0);
        nextCycle();

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h8000_0000, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
        @(negedge clk_i);
        checkOutput("boot_req0", 32'(instr_req_o), 32'd1);
        checkOutput("boot_addr0", instr_addr_o, 32'h8000_0000);
        nextCycle();
        @(negedge clk_i);
        checkOutput("boot_addr1", instr_addr_o, 32'h8000_0004);
`ifdef MIRISCV_PREFETCH_BYPASS_EN
        checkOutput("boot_valid_early", 32'(f_valid_o), 32'd1);
        checkOutput("boot_pc_early", f_current_pc_o, 32'h8000_0000);
`else
        checkOutput("boot_valid_early", 32'(f_valid_o), 32'd0);
`endif
        nextCycle();
        @(negedge clk_i);
        checkOutput("boot_valid", 32'(f_valid_o), 32'd1);
        checkOutput("boot_addr2", instr_addr_o, 32'h8000_0008);
`ifdef MIRISCV_PREFETCH_BYPASS_EN
        checkOutput("boot_pc", f_current_pc_o, 32'h8000_0004);
        checkOutput("boot_instr", f_instr_o, 32'h5EAD_BEEB);
`else
        checkOutput("boot_pc", f_current_pc_o, 32'h8000_0000);
        checkOutput("boot_instr", f_instr_o, 32'h5EAD_BEEF);
        checkOutput("boot_npc", f_next_pc_o, 32'h8000_0004);
`endif
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 10);

        // Decode stall: buffer fills, fetching pauses, nothing is lost on release.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 10);
        @(negedge clk_i);
        checkOutput("stall_full_req", 32'(instr_req_o), 32'd0);
        checkOutput("stall_full_valid", 32'(f_valid_o), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 12);

        // Slow memory, then redirect while two requests are in flight.
        mem_lat = 3;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 12);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk_i);
            #3;
            if (inflight.size() == 2 && !instr_rvalid_i) found = 1'b1;
        end
        checkOutput("two_inflight_wait", 32'(found), 32'd1);
        cu_force_f_i  = 1'b1;
        cu_force_pc_i = 32'h0000_0100;
        nextCycle();
        cu_force_f_i  = 1'b0;
        @(negedge clk_i);
        found = f_valid_o;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk_i);
            found = f_valid_o;
        end
        checkOutput("force100_valid_wait", 32'(found), 32'd1);
        if (found) begin
            checkOutput("force100_pc", f_current_pc_o, 32'h0000_0100);
            checkOutput("force100_npc", f_next_pc_o, 32'h0000_0104);
            checkOutput("force100_instr", f_instr_o, 32'hDEAD_BFEF);
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 12);

        // Kill together with stall while a response is arriving.
        mem_lat = 1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 8);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk_i);
            #3;
            if (instr_rvalid_i) found = 1'b1;
        end
        checkOutput("kill_rvalid_wait", 32'(found), 32'd1);
        saved_pc     = m_fetch_pc;
        cu_kill_f_i  = 1'b1;
        cu_stall_f_i = 1'b1;
        @(negedge clk_i);
        checkOutput("kill_valid", 32'(f_valid_o), 32'd0);
        checkOutput("kill_stall_req", 32'(f_stall_req_o), 32'd0);
        checkOutput("kill_req", 32'(instr_req_o), 32'd0);
        nextCycle();
        cu_kill_f_i  = 1'b0;
        cu_stall_f_i = 1'b0;
        @(negedge clk_i);
        found = instr_req_o;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk_i);
            found = instr_req_o;
        end
        checkOutput("kill_resume_wait", 32'(found), 32'd1);
        if (found) checkOutput("kill_resume_addr", instr_addr_o, saved_pc);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 10);

        // Fetch PC wraps past the top of the address space.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
        @(negedge clk_i);
        checkOutput("wrap_addr0", instr_addr_o, 32'hFFFF_FFFC);
        nextCycle();
        @(negedge clk_i);
        checkOutput("wrap_req1", 32'(instr_req_o), 32'd1);
        checkOutput("wrap_addr1", instr_addr_o, 32'h0000_0000);
        found = f_valid_o;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk_i);
            found = f_valid_o;
        end
        checkOutput("wrap_valid_wait", 32'(found), 32'd1);
        if (found) begin
            checkOutput("wrap_pc", f_current_pc_o, 32'hFFFF_FFFC);
            checkOutput("wrap_npc", f_next_pc_o, 32'h0000_0000);
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 8);

        // Reset in the middle of traffic, then reboot elsewhere.
        arstn_i = 1'b0;
        @(negedge clk_i);
        checkResetOutputs("mid_rst");
        nextCycle();
        nextCycle();
        arstn_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
        @(negedge clk_i);
        found = f_valid_o;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk_i);
            found = f_valid_o;
        end
        checkOutput("reboot_valid_wait", 32'(found), 32'd1);
        if (found) checkOutput("reboot_pc", f_current_pc_o, 32'h0000_0200);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
